pkt_master_ctrl: RTL and testbench

- Sequences the shared packet buffer between two ingress sources, the processor pipeline and four egress destinations.
- Fills the buffer from an arbitrated source, then starts the pipeline and waits for its done signal.
- Routes the buffer to the destination chosen by the Master_Control instruction code, or drops the packet.
- Sits between the network interfaces and the pipeline; consumes the decoder's master code and pipeline-done outputs.

---
 rtl/pkt_master_ctrl_if.sv | 37 +++
 rtl/pkt_master_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pkt_master_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_master_ctrl_if.sv
// Bundles the buffer, pipeline and source/destination handshakes of the packet master controller.
// The controller connects through the master modport; the surrounding datapath uses the slave modport.
interface pkt_master_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
);
    logic [1:0]        src_req;
    logic [1:0]        src_grant;
    logic              src_valid;
    logic              src_last;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              pl_start;
    logic              pl_done;
    logic              mst_valid;
    logic [2:0]        mst_code;
    logic [3:0]        dst_grant;
    logic              dst_ready;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              dst_last;
    logic [ADDR_W:0]   pkt_len;
    logic              busy;
    logic [CNT_W-1:0]  drop_cnt;

    modport master (
        input  src_req, src_valid, src_last, pl_done, mst_valid, mst_code, dst_ready,
        output src_grant, wr_en, wr_addr, pl_start, dst_grant, rd_en, rd_addr,
               dst_last, pkt_len, busy, drop_cnt
    );

    modport slave (
        output src_req, src_valid, src_last, pl_done, mst_valid, mst_code, dst_ready,
        input  src_grant, wr_en, wr_addr, pl_start, dst_grant, rd_en, rd_addr,
               dst_last, pkt_len, busy, drop_cnt
    );
endinterface

// File: rtl/pkt_master_ctrl.sv
// Packet buffer sequencer: fill from an arbitrated source, run the pipeline,
// then drain to the destination picked by the Master_Control code or drop the packet.
module pkt_master_ctrl #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    pkt_master_ctrl_if.master io_pkt
);

    typedef enum logic [2:0] {IDLE, FILL, RUN, DRAIN, DROP} ctrlState_e;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    ctrlState_e        r_state;
    logic [1:0]        r_srcGrant;
    logic              r_rrPtr;
    logic              r_prefValid;
    logic              r_prefSrc;
    logic              r_destValid;
    logic [1:0]        r_dest;
    logic [ADDR_W-1:0] r_wrAddr;
    logic [ADDR_W:0]   r_pktLen;
    logic              r_ovf;
    logic [ADDR_W-1:0] r_rdAddr;
    logic              r_plStart;
    logic [CNT_W-1:0]  r_dropCnt;

    logic       w_wrEn;
    logic       w_rdEn;
    logic       w_dstLast;
    logic       w_grantHit;
    logic       w_grantSrc;
    logic       w_usePref;
    logic       w_destValidNext;
    logic [1:0] w_destNext;
    logic       w_prefValidNext;
    logic       w_prefSrcNext;

    assign w_wrEn    = (r_state == FILL) && io_pkt.src_valid && !r_ovf;
    assign w_rdEn    = (r_state == DRAIN) && io_pkt.dst_ready;
    assign w_dstLast = (r_state == DRAIN) && ({1'b0, r_rdAddr} == (r_pktLen - LEN_ONE));

    // A pending preferred source beats round-robin; otherwise start the search at the pointer.
    always_comb begin
        w_grantHit = 1'b0;
        w_grantSrc = r_rrPtr;
        w_usePref  = 1'b0;
        if (r_prefValid && io_pkt.src_req[r_prefSrc]) begin
            w_grantHit = 1'b1;
            w_grantSrc = r_prefSrc;
            w_usePref  = 1'b1;
        end else if (io_pkt.src_req[r_rrPtr]) begin
            w_grantHit = 1'b1;
            w_grantSrc = r_rrPtr;
        end else if (io_pkt.src_req[~r_rrPtr]) begin
            w_grantHit = 1'b1;
            w_grantSrc = ~r_rrPtr;
        end
    end

    // This cycle's master code is folded in first so a coincident pl_done sees it.
    always_comb begin
        w_destValidNext = r_destValid;
        w_destNext      = r_dest;
        w_prefValidNext = r_prefValid;
        w_prefSrcNext   = r_prefSrc;
        if (r_state == RUN && io_pkt.mst_valid) begin
            case (io_pkt.mst_code)
                3'b000: w_destValidNext = 1'b0;
                3'b001: begin w_prefValidNext = 1'b1; w_prefSrcNext = 1'b0; end
                3'b010: begin w_prefValidNext = 1'b1; w_prefSrcNext = 1'b1; end
                3'b011: begin w_destValidNext = 1'b1; w_destNext = 2'd0; end
                3'b100: begin w_destValidNext = 1'b1; w_destNext = 2'd1; end
                3'b101: begin w_destValidNext = 1'b1; w_destNext = 2'd2; end
                3'b110: begin w_destValidNext = 1'b1; w_destNext = 2'd3; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_srcGrant  <= 2'b00;
            r_rrPtr     <= 1'b0;
            r_prefValid <= 1'b0;
            r_prefSrc   <= 1'b0;
            r_destValid <= 1'b0;
            r_dest      <= 2'd0;
            r_wrAddr    <= '0;
            r_pktLen    <= '0;
            r_ovf       <= 1'b0;
            r_rdAddr    <= '0;
            r_plStart   <= 1'b0;
            r_dropCnt   <= '0;
        end else begin
            r_plStart <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grantHit) begin
                        r_state    <= FILL;
                        r_srcGrant <= w_grantSrc ? 2'b10 : 2'b01;
                        r_wrAddr   <= '0;
                        r_pktLen   <= '0;
                        r_ovf      <= 1'b0;
                        if (w_usePref) r_prefValid <= 1'b0;
                        else           r_rrPtr     <= ~w_grantSrc;
                    end
                end
                FILL: begin
                    if (w_wrEn) begin
                        r_wrAddr <= r_wrAddr + ADDR_ONE;
                        r_pktLen <= r_pktLen + LEN_ONE;
                        if (r_wrAddr == ADDR_MAX) r_ovf <= 1'b1;
                    end
                    // A packet that exactly fills the buffer still runs: r_ovf is only seen next cycle.
                    if (io_pkt.src_valid && io_pkt.src_last) begin
                        r_srcGrant <= 2'b00;
                        if (r_ovf) begin
                            r_state <= DROP;
                        end else begin
                            r_state   <= RUN;
                            r_plStart <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_destValid <= w_destValidNext;
                    r_dest      <= w_destNext;
                    r_prefValid <= w_prefValidNext;
                    r_prefSrc   <= w_prefSrcNext;
                    if (io_pkt.pl_done) begin
                        if (w_destValidNext) begin
                            r_state  <= DRAIN;
                            r_rdAddr <= '0;
                        end else begin
                            r_state <= DROP;
                        end
                    end
                end
                DRAIN: begin
                    if (io_pkt.dst_ready) begin
                        if (w_dstLast) begin
                            r_state     <= IDLE;
                            r_destValid <= 1'b0;
                            r_rdAddr    <= '0;
                        end else begin
                            r_rdAddr <= r_rdAddr + ADDR_ONE;
                        end
                    end
                end
                DROP: begin
                    if (r_dropCnt != CNT_MAX) r_dropCnt <= r_dropCnt + CNT_ONE;
                    r_destValid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_pkt.src_grant = r_srcGrant;
    assign io_pkt.wr_en     = w_wrEn;
    assign io_pkt.wr_addr   = r_wrAddr;
    assign io_pkt.pl_start  = r_plStart;
    assign io_pkt.dst_grant = (r_state == DRAIN) ? (4'b0001 << r_dest) : 4'b0000;
    assign io_pkt.rd_en     = w_rdEn;
    assign io_pkt.rd_addr   = r_rdAddr;
    assign io_pkt.dst_last  = w_dstLast;
    assign io_pkt.pkt_len   = r_pktLen;
    assign io_pkt.busy      = (r_state != IDLE);
    assign io_pkt.drop_cnt  = r_dropCnt;

endmodule

// File: tb/tb_pkt_master_ctrl.sv
// Scoreboard bench for pkt_master_ctrl on a 4-word buffer with a 2-bit drop counter,
// so overflow and counter saturation are reachable with short packets.
module tb_pkt_master_ctrl;

    localparam int ADDR_W = 2;
    localparam int CNT_W  = 2;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              last;
        logic [3:0]        grant;
    } rdItem_t;

    logic clk;
    logic rst_n;

    pkt_master_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) io ();

    pkt_master_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_pkt (io.master)
    );

    int vectors     = 0;
    int miscompares = 0;
    int plStartCnt  = 0;

    logic [ADDR_W-1:0] wrExp[$];
    rdItem_t           rdExp[$];
    logic [1:0]        curGrant;
    logic [ADDR_W-1:0] monAddr;
    rdItem_t           monItem;

    logic       mPtr;
    logic       mPrefValid;
    logic       mPref;
    logic       mDestValid;
    logic [1:0] mDest;
    int         mLen;
    int         expDrop;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard side: pop expected writes/reads as the DUT strobes them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (io.pl_start) plStartCnt++;
            if (io.wr_en) begin
                checkOutput("wrGrant", 32'(io.src_grant), 32'(curGrant));
                if (wrExp.size() == 0) begin
                    checkOutput("wrSpurious", 32'(io.wr_en), 0);
                end else begin
                    monAddr = wrExp.pop_front();
                    checkOutput("wrAddr", 32'(io.wr_addr), 32'(monAddr));
                end
            end
            if (io.dst_grant != 4'b0000) begin
                checkOutput("rdEn", 32'(io.rd_en), 32'(io.dst_ready));
                if (rdExp.size() == 0) begin
                    checkOutput("rdSpurious", 32'(io.dst_grant), 0);
                end else begin
                    monItem = rdExp[0];
                    checkOutput("rdAddr", 32'(io.rd_addr), 32'(monItem.addr));
                    checkOutput("dstLast", 32'(io.dst_last), 32'(monItem.last));
                    checkOutput("dstGrant", 32'(io.dst_grant), 32'(monItem.grant));
                    if (io.rd_en) void'(rdExp.pop_front());
                end
            end else if (io.rd_en) begin
                checkOutput("rdOutsideDrain", 32'(io.rd_en), 0);
            end
        end
    end

    task automatic checkResetOutputs();
        checkOutput("rstSrcGrant", 32'(io.src_grant), 0);
        checkOutput("rstWrEn", 32'(io.wr_en), 0);
        checkOutput("rstWrAddr", 32'(io.wr_addr), 0);
        checkOutput("rstPlStart", 32'(io.pl_start), 0);
        checkOutput("rstDstGrant", 32'(io.dst_grant), 0);
        checkOutput("rstRdEn", 32'(io.rd_en), 0);
        checkOutput("rstRdAddr", 32'(io.rd_addr), 0);
        checkOutput("rstDstLast", 32'(io.dst_last), 0);
        checkOutput("rstPktLen", 32'(io.pkt_len), 0);
        checkOutput("rstBusy", 32'(io.busy), 0);
        checkOutput("rstDropCnt", 32'(io.drop_cnt), 0);
    endtask

    task automatic resetModel();
        mPtr       = 1'b0;
        mPrefValid = 1'b0;
        mPref      = 1'b0;
        mDestValid = 1'b0;
        mDest      = 2'd0;
        mLen       = 0;
        expDrop    = 0;
    endtask

    task automatic applyCodeModel(input logic [2:0] c);
        case (c)
            3'b000: mDestValid = 1'b0;
            3'b001: begin mPrefValid = 1'b1; mPref = 1'b0; end
            3'b010: begin mPrefValid = 1'b1; mPref = 1'b1; end
            3'b011: begin mDestValid = 1'b1; mDest = 2'd0; end
            3'b100: begin mDestValid = 1'b1; mDest = 2'd1; end
            3'b101: begin mDestValid = 1'b1; mDest = 2'd2; end
            3'b110: begin mDestValid = 1'b1; mDest = 2'd3; end
            default: ;
        endcase
    endtask

    task automatic arbGrant(input logic [1:0] req);
        logic       g;
        logic [1:0] expG;
        if (mPrefValid && req[mPref]) begin
            g = mPref;
            mPrefValid = 1'b0;
        end else begin
            g = req[mPtr] ? mPtr : ~mPtr;
            mPtr = ~g;
        end
        expG     = g ? 2'b10 : 2'b01;
        curGrant = expG;
        @(posedge clk); #1;
        io.src_req = req;
        for (int i = 0; i < 8 && io.src_grant == 2'b00; i++) @(negedge clk);
        checkOutput("srcGrant", 32'(io.src_grant), 32'(expG));
    endtask

    // Streams n words; src_req is dropped during FILL, which the grant must ignore.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            io.src_req   = 2'b00;
            io.src_valid = 1'b1;
            io.src_last  = (i == n - 1);
            if (i < DEPTH) wrExp.push_back(ADDR_W'(i));
        end
        @(posedge clk); #1;
        io.src_valid = 1'b0;
        io.src_last  = 1'b0;
        mLen = (n > DEPTH) ? DEPTH : n;
    endtask

    task automatic sendCode(input logic [2:0] c);
        @(posedge clk); #1;
        io.mst_valid = 1'b1;
        io.mst_code  = c;
        applyCodeModel(c);
        @(posedge clk); #1;
        io.mst_valid = 1'b0;
    endtask

    task automatic pipeDone(input bit withCode, input logic [2:0] c);
        rdItem_t it;
        @(posedge clk); #1;
        io.pl_done   = 1'b1;
        io.mst_valid = withCode;
        io.mst_code  = c;
        if (withCode) applyCodeModel(c);
        if (mDestValid) begin
            for (int i = 0; i < mLen; i++) begin
                it.addr  = ADDR_W'(i);
                it.last  = (i == mLen - 1);
                it.grant = 4'b0001 << mDest;
                rdExp.push_back(it);
            end
        end else if (expDrop < CNT_SAT) begin
            expDrop++;
        end
        mDestValid = 1'b0;
        @(posedge clk); #1;
        io.pl_done   = 1'b0;
        io.mst_valid = 1'b0;
    endtask

    task automatic drainPattern(input logic [7:0] pat, input int len);
        for (int i = 0; i < len; i++) begin
            io.dst_ready = pat[i];
            @(posedge clk); #1;
        end
        io.dst_ready = 1'b1;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 40 && io.busy; i++) @(negedge clk);
        if (io.busy) checkOutput("idleTimeout", 32'(io.busy), 0);
    endtask

    task automatic checkEnd(input int startCnt, input int expStarts);
        checkOutput("plStartCnt", 32'(plStartCnt - startCnt), 32'(expStarts));
        checkOutput("dropCnt", 32'(io.drop_cnt), 32'(expDrop));
        checkOutput("dstGrantIdle", 32'(io.dst_grant), 0);
        checkOutput("busyIdle", 32'(io.busy), 0);
        checkOutput("wrQueueLeft", 32'(wrExp.size()), 0);
        checkOutput("rdQueueLeft", 32'(rdExp.size()), 0);
    endtask

    task automatic runPacket(input logic [1:0] req, input int n,
                             input bit u1, input logic [2:0] c1,
                             input bit u2, input logic [2:0] c2,
                             input bit doneCode, input logic [2:0] dc,
                             input logic [7:0] pat, input int patLen);
        int startCnt;
        startCnt = plStartCnt;
        arbGrant(req);
        applyStimulus(n);
        if (n > DEPTH) begin
            if (expDrop < CNT_SAT) expDrop++;
            waitIdle();
            checkOutput("pktLenOvf", 32'(io.pkt_len), 32'(DEPTH));
            checkEnd(startCnt, 0);
        end else begin
            @(negedge clk);
            checkOutput("pktLen", 32'(io.pkt_len), 32'(n));
            checkOutput("busyRun", 32'(io.busy), 1);
            if (u1) sendCode(c1);
            if (u2) sendCode(c2);
            pipeDone(doneCode, dc);
            drainPattern(pat, patLen);
            waitIdle();
            checkEnd(startCnt, 1);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        io.src_req   = 2'b00;
        io.src_valid = 1'b0;
        io.src_last  = 1'b0;
        io.pl_done   = 1'b0;
        io.mst_valid = 1'b0;
        io.mst_code  = 3'b000;
        io.dst_ready = 1'b1;
        curGrant     = 2'b00;
        resetModel();
        #2;
        checkResetOutputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] round-robin over three packets with both sources requesting");
        runPacket(2'b11, 2, 1, 3'b011, 0, 3'b000, 0, 3'b000, 8'h00, 0);
        runPacket(2'b11, 2, 1, 3'b011, 0, 3'b000, 0, 3'b000, 8'h00, 0);
        runPacket(2'b11, 2, 1, 3'b011, 0, 3'b000, 0, 3'b000, 8'h00, 0);

        $display("[TB] three-word packet from src0 routed to dest1");
        runPacket(2'b01, 3, 1, 3'b100, 0, 3'b000, 0, 3'b000, 8'h00, 0);

        $display("[TB] preferred source src1 then dest3; next grant follows the preference");
        runPacket(2'b10, 2, 1, 3'b010, 1, 3'b110, 0, 3'b000, 8'h00, 0);
        runPacket(2'b11, 3, 0, 3'b000, 0, 3'b000, 1, 3'b101, 8'h00, 0);

        $display("[TB] drop paths and counter saturation");
        runPacket(2'b01, 1, 0, 3'b000, 0, 3'b000, 0, 3'b000, 8'h00, 0);
        runPacket(2'b10, 2, 1, 3'b101, 1, 3'b000, 0, 3'b000, 8'h00, 0);
        runPacket(2'b01, 6, 0, 3'b000, 0, 3'b000, 0, 3'b000, 8'h00, 0);
        runPacket(2'b10, 2, 1, 3'b011, 0, 3'b000, 1, 3'b000, 8'h00, 0);
        runPacket(2'b01, 1, 1, 3'b111, 0, 3'b000, 0, 3'b000, 8'h00, 0);

        $display("[TB] full-buffer packet and stalled drain");
        runPacket(2'b10, 4, 1, 3'b100, 0, 3'b000, 0, 3'b000, 8'h00, 0);
        runPacket(2'b11, 3, 1, 3'b011, 0, 3'b000, 0, 3'b000, 8'b0001_1001, 5);

        $display("[TB] reset asserted in the middle of a drain");
        arbGrant(2'b01);
        applyStimulus(3);
        @(negedge clk);
        sendCode(3'b011);
        io.dst_ready = 1'b0;
        pipeDone(0, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("drainBeforeReset", 32'(io.dst_grant), 32'h1);
        rst_n = 1'b0;
        #1;
        checkResetOutputs();
        rdExp.delete();
        resetModel();
        io.dst_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        runPacket(2'b10, 2, 1, 3'b110, 0, 3'b000, 0, 3'b000, 8'h00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
